// File: rtl/inst_fetch_seq.sv
// 6502 instruction fetch sequencer: fetches opcode plus 0-2 operand bytes and issues them to execute.
// Optional instruction counter output enabled by defining INST_FETCH_COUNT_EN.
module inst_fetch_seq #(
    parameter int unsigned        ADDR_W   = 16,
    parameter logic [ADDR_W-1:0]  RESET_PC = ADDR_W'(16'h0200)
) (
    input  logic              clk,
    input  logic              rst,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_req,
    input  logic              mem_ack,
    input  logic [7:0]        mem_rdata,
    output logic [7:0]        op_byte,
    input  logic [1:0]        op_len,
    output logic              inst_valid,
    input  logic              inst_ready,
    output logic [7:0]        inst_opcode,
    output logic [15:0]       inst_operand,
    output logic [ADDR_W-1:0] inst_pc,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic [ADDR_W-1:0] pc
`ifdef INST_FETCH_COUNT_EN
    ,
    output logic [15:0]       inst_count
`endif
);

    typedef enum logic [2:0] {
        FETCH_OP,
        LEN,
        FETCH_LO,
        FETCH_HI,
        ISSUE
    } state_t;

    state_t      state;
    state_t      state_n;
    logic [15:0] operand;
    logic        len3;
    logic        ack_ok;
    logic        handshake;

    // NOTE: mem_req is gated by rst so the request stays low while reset is held and
    // rises in the first cycle after release, even though state already reads FETCH_OP.
    assign mem_req = !rst && (state == FETCH_OP || state == FETCH_LO || state == FETCH_HI);

    // A redirect abandons the in-flight fetch, so an ack in that cycle is discarded.
    assign ack_ok       = mem_req && mem_ack && !redirect;
    assign mem_addr     = pc;
    assign inst_valid   = (state == ISSUE);
    assign handshake    = inst_valid && inst_ready;
    assign inst_opcode  = op_byte;
    assign inst_operand = operand;

    always_comb begin
        // NOTE: default assignment first so every path drives state_n and no latch is inferred.
        state_n = state;
        case (state)
            FETCH_OP: if (ack_ok) state_n = LEN;
            LEN:      state_n = (op_len[1]) ? FETCH_LO : ISSUE;
            FETCH_LO: if (ack_ok) state_n = len3 ? FETCH_HI : ISSUE;
            FETCH_HI: if (ack_ok) state_n = ISSUE;
            ISSUE:    if (handshake) state_n = FETCH_OP;
            default:  state_n = FETCH_OP;
        endcase
        if (redirect) state_n = FETCH_OP;
    end

    // NOTE: all sequential state uses non-blocking assignments so every register samples
    // the pre-edge values of its neighbours.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= FETCH_OP;
            pc      <= RESET_PC;
            op_byte <= '0;
            inst_pc <= '0;
            operand <= '0;
            len3    <= 1'b0;
        end else begin
            state <= state_n;
            if (redirect) begin
                pc <= redirect_pc;
            end else if (ack_ok) begin
                pc <= pc + ADDR_W'(1);
            end
            if (ack_ok) begin
                case (state)
                    FETCH_OP: begin
                        op_byte <= mem_rdata;
                        inst_pc <= pc;
                        operand <= '0;
                    end
                    FETCH_LO: operand[7:0]  <= mem_rdata;
                    FETCH_HI: operand[15:8] <= mem_rdata;
                    default:  ;
                endcase
            end
            if (state == LEN) len3 <= (op_len == 2'd3);
        end
    end

`ifdef INST_FETCH_COUNT_EN
    // Counts accepted instructions; deliberately survives redirects.
    always_ff @(posedge clk) begin
        if (rst) begin
            inst_count <= '0;
        end else if (handshake) begin
            inst_count <= inst_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_inst_fetch_seq.sv
// Self-checking bench for inst_fetch_seq: directed vectors, issue scoreboard, bus-level checks.
// Inputs driven 1ns after posedge; everything sampled on negedge.
module tb_inst_fetch_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] mem_addr;
    logic        mem_req;
    logic        mem_ack;
    logic [7:0]  mem_rdata;
    logic [7:0]  op_byte;
    logic [1:0]  op_len;
    logic        inst_valid;
    logic        inst_ready;
    logic [7:0]  inst_opcode;
    logic [15:0] inst_operand;
    logic [15:0] inst_pc;
    logic        redirect;
    logic [15:0] redirect_pc;
    logic [15:0] pc;
`ifdef INST_FETCH_COUNT_EN
    logic [15:0] inst_count;
`endif

    inst_fetch_seq dut (
        .clk          (clk),
        .rst          (rst),
        .mem_addr     (mem_addr),
        .mem_req      (mem_req),
        .mem_ack      (mem_ack),
        .mem_rdata    (mem_rdata),
        .op_byte      (op_byte),
        .op_len       (op_len),
        .inst_valid   (inst_valid),
        .inst_ready   (inst_ready),
        .inst_opcode  (inst_opcode),
        .inst_operand (inst_operand),
        .inst_pc      (inst_pc),
        .redirect     (redirect),
        .redirect_pc  (redirect_pc),
`ifdef INST_FETCH_COUNT_EN
        .inst_count   (inst_count),
`endif
        .pc           (pc)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic [7:0]  op;
        logic [15:0] operand;
        logic [15:0] pc;
    } inst_t;

    inst_t exp_q[$];
    inst_t got;

    // Memory model: byte array, ack after ack_delay waiting cycles.
    logic [7:0] mem [0:65535];
    int         ack_delay = 0;
    int         wait_cnt  = 0;

    assign mem_ack   = mem_req && (wait_cnt == ack_delay);
    assign mem_rdata = mem[mem_addr];

    always @(posedge clk) begin
        if (mem_req && !mem_ack && !redirect) wait_cnt <= wait_cnt + 1;
        else wait_cnt <= 0;
    end

    // Decoder model: A9 -> 2 bytes, 4C -> 3 bytes, 02 -> 0 (treated as 1), else 1.
    function automatic logic [1:0] len_of(input logic [7:0] op);
        case (op)
            8'hA9:   return 2'd2;
            8'h4C:   return 2'd3;
            8'h02:   return 2'd0;
            default: return 2'd1;
        endcase
    endfunction

    assign op_len = len_of(op_byte);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Scoreboard monitor: every accepted instruction must match the oldest expectation.
    always @(negedge clk) begin
        if (inst_valid && inst_ready) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_issue: got op=%h operand=%h pc=%h expected none",
                         inst_opcode, inst_operand, inst_pc);
            end else begin
                got = exp_q.pop_front();
                check("issue_opcode",  32'(inst_opcode),  32'(got.op));
                check("issue_operand", 32'(inst_operand), 32'(got.operand));
                check("issue_pc",      32'(inst_pc),      32'(got.pc));
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_redirect(input logic [15:0] addr);
        redirect    = 1'b1;
        redirect_pc = addr;
        cyc();
        redirect    = 1'b0;
    endtask

    task automatic exp_bus(input string name, input logic req, input logic [15:0] addr);
        @(negedge clk);
        check({name, "_req"},  32'(mem_req),  32'(req));
        check({name, "_addr"}, 32'(mem_addr), 32'(addr));
        cyc();
    endtask

    task automatic wait_valid(input string name, input int max);
        int n = 0;
        @(negedge clk);
        while (!inst_valid && n < max) begin
            cyc();
            @(negedge clk);
            n++;
        end
        check(name, 32'(inst_valid), 32'd1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_mem_req"},  32'(mem_req),      32'd0);
        check({tag, "_valid"},    32'(inst_valid),   32'd0);
        check({tag, "_mem_addr"}, 32'(mem_addr),     32'h0200);
        check({tag, "_pc"},       32'(pc),           32'h0200);
        check({tag, "_op_byte"},  32'(op_byte),      32'd0);
        check({tag, "_opcode"},   32'(inst_opcode),  32'd0);
        check({tag, "_operand"},  32'(inst_operand), 32'd0);
        check({tag, "_inst_pc"},  32'(inst_pc),      32'd0);
`ifdef INST_FETCH_COUNT_EN
        check({tag, "_count"},    32'(inst_count),   32'd0);
`endif
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        int hs;
        for (int i = 0; i < 65536; i++) mem[i] = 8'hEA;
        mem[16'h0200] = 8'hEA;
        mem[16'h0201] = 8'h02;
        mem[16'h0300] = 8'hA9;
        mem[16'h0301] = 8'h42;
        mem[16'hFFFE] = 8'h4C;
        mem[16'hFFFF] = 8'h34;
        mem[16'h0000] = 8'h12;
        mem[16'h0400] = 8'hA9;
        mem[16'h0401] = 8'h77;
        mem[16'h0600] = 8'h4C;

        rst         = 1'b1;
        redirect    = 1'b0;
        redirect_pc = '0;
        inst_ready  = 1'b0;

        // Reset state.
        repeat (2) cyc();
        @(negedge clk);
        check_reset_outputs("reset");

        // 1-byte instruction, zero-wait memory, ready high: valid on cycle 3.
        cyc();
        rst        = 1'b0;
        inst_ready = 1'b1;
        exp_q.push_back('{op: 8'hEA, operand: 16'h0000, pc: 16'h0200});
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            check($sformatf("t1_valid_c%0d", c), 32'(inst_valid), 32'(c == 3));
            if (c == 1) begin
                check("t1_req_c1",  32'(mem_req),  32'd1);
                check("t1_addr_c1", 32'(mem_addr), 32'h0200);
            end
            if (c == 4) begin
                check("t1_req_c4",  32'(mem_req),  32'd1);
                check("t1_addr_c4", 32'(mem_addr), 32'h0201);
            end
            cyc();
            if (c == 3) inst_ready = 1'b0;
        end

        // 2-byte instruction at 0300 after redirect.
        do_redirect(16'h0300);
        exp_q.push_back('{op: 8'hA9, operand: 16'h0042, pc: 16'h0300});
        exp_bus("t2_op",  1'b1, 16'h0300);
        exp_bus("t2_len", 1'b0, 16'h0301);
        exp_bus("t2_lo",  1'b1, 16'h0301);
        @(negedge clk);
        check("t2_valid", 32'(inst_valid), 32'd1);
        check("t2_pc",    32'(pc),         32'h0302);
        cyc();
        inst_ready = 1'b1;
        @(negedge clk);
        cyc();
        inst_ready = 1'b0;

        // 3-byte instruction across FFFF wrap, two wait cycles per byte.
        ack_delay = 2;
        do_redirect(16'hFFFE);
        exp_q.push_back('{op: 8'h4C, operand: 16'h1234, pc: 16'hFFFE});
        for (int k = 0; k < 3; k++) exp_bus("t3_op", 1'b1, 16'hFFFE);
        exp_bus("t3_len", 1'b0, 16'hFFFF);
        for (int k = 0; k < 3; k++) exp_bus("t3_lo", 1'b1, 16'hFFFF);
        for (int k = 0; k < 3; k++) exp_bus("t3_hi", 1'b1, 16'h0000);

        // Hold ready low five cycles in ISSUE; outputs must not move.
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            if (k == 1) check("t3_pc_wrap", 32'(pc), 32'h0001);
            check("t4_valid",   32'(inst_valid),   32'd1);
            check("t4_req",     32'(mem_req),      32'd0);
            check("t4_opcode",  32'(inst_opcode),  32'h4C);
            check("t4_operand", 32'(inst_operand), 32'h1234);
            check("t4_inst_pc", 32'(inst_pc),      32'hFFFE);
            cyc();
        end
        inst_ready = 1'b1;
        @(negedge clk);
        cyc();
        inst_ready = 1'b0;
        @(negedge clk);
        check("t4_after_valid", 32'(inst_valid), 32'd0);
        check("t4_after_req",   32'(mem_req),    32'd1);
        check("t4_after_addr",  32'(mem_addr),   32'h0001);
        cyc();

        // Redirect during FETCH_LO with a simultaneous ack: capture discarded.
        ack_delay = 0;
        do_redirect(16'h0400);
        exp_bus("t5_op",  1'b1, 16'h0400);
        exp_bus("t5_len", 1'b0, 16'h0401);
        redirect    = 1'b1;
        redirect_pc = 16'h8000;
        @(negedge clk);
        check("t5_lo_req", 32'(mem_req), 32'd1);
        check("t5_lo_ack", 32'(mem_ack), 32'd1);
        cyc();
        redirect = 1'b0;
        @(negedge clk);
        check("t5_addr",    32'(mem_addr),     32'h8000);
        check("t5_valid",   32'(inst_valid),   32'd0);
        check("t5_operand", 32'(inst_operand), 32'h0000);
        check("t5_req",     32'(mem_req),      32'd1);
        cyc();

        // Redirect in the same cycle as an ISSUE handshake: instruction still accepted.
        wait_valid("t5b_valid", 10);
        cyc();
        exp_q.push_back('{op: 8'hEA, operand: 16'h0000, pc: 16'h8000});
        inst_ready  = 1'b1;
        redirect    = 1'b1;
        redirect_pc = 16'h0500;
        @(negedge clk);
        cyc();
        inst_ready = 1'b0;
        redirect   = 1'b0;
        @(negedge clk);
        check("t5b_valid_drop", 32'(inst_valid), 32'd0);
        check("t5b_addr",       32'(mem_addr),   32'h0500);
`ifdef INST_FETCH_COUNT_EN
        check("t5b_count",      32'(inst_count), 32'd4);
`endif
        cyc();

        // Reset applied in the middle of FETCH_HI.
        ack_delay = 2;
        do_redirect(16'h0600);
        for (int k = 0; k < 3; k++) exp_bus("t6_op", 1'b1, 16'h0600);
        exp_bus("t6_len", 1'b0, 16'h0601);
        for (int k = 0; k < 3; k++) exp_bus("t6_lo", 1'b1, 16'h0601);
        rst = 1'b1;
        @(negedge clk);
        check("t6_hi_req_in_rst", 32'(mem_req), 32'd0);
        cyc();
        @(negedge clk);
        check_reset_outputs("t6_rst");
        cyc();

        // Three back-to-back accepted instructions from 0200 (0201 has length 0 -> 1).
        rst        = 1'b0;
        ack_delay  = 0;
        inst_ready = 1'b1;
        exp_q.push_back('{op: 8'hEA, operand: 16'h0000, pc: 16'h0200});
        exp_q.push_back('{op: 8'h02, operand: 16'h0000, pc: 16'h0201});
        exp_q.push_back('{op: 8'hEA, operand: 16'h0000, pc: 16'h0202});
        hs = 0;
        for (int n = 0; n < 40 && hs < 3; n++) begin
            @(negedge clk);
            if (inst_valid && inst_ready) hs++;
            cyc();
        end
        inst_ready = 1'b0;
        check("t6_handshakes", 32'(hs), 32'd3);
`ifdef INST_FETCH_COUNT_EN
        @(negedge clk);
        check("t6_count", 32'(inst_count), 32'd3);
`endif

        repeat (3) cyc();
        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
